// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoring path.
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    SCORED    = 2'd1,
    PAUSE     = 2'd2,
    GAME_OVER = 2'd3
  } score_state_t;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam logic PLAYER_FIRST  = 1'b0;
  localparam logic PLAYER_SECOND = 1'b1;

endpackage

// File: rtl/rise_det.sv
// One-bit rising-edge detector: input compared against its registered previous value.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/score_ctl.sv
// Match scorekeeper: awards points on ball exit, detects match end, holds serve.
// Optional serve pause after each point is enabled by defining SCORE_PAUSE_EN.
module score_ctl
  import pong_pkg::*;
#(
  parameter int WIN_POINTS   = 9,
  parameter int X_MID        = HOR_PIXELS / 2,
  parameter int PAUSE_CYCLES = 32_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        score_flag,
  input  logic [10:0] xpos,
  input  logic        new_game,
  output logic [3:0]  points_first_player,
  output logic [3:0]  points_second_player,
  output logic        score_evt,
  output logic        serve_hold,
  output logic        game_over,
  output logic        winner
);

  localparam logic [3:0]  WIN   = 4'(WIN_POINTS);
  localparam logic [10:0] X_SPL = 11'(X_MID);

  score_state_t state_q, state_d;
  logic [3:0]   p1_q, p1_d, p2_q, p2_d;
  logic         evt_q, evt_d;
  logic         winner_q, winner_d;
  logic         flag_rise, ng_rise;

`ifdef SCORE_PAUSE_EN
  localparam logic [25:0] PAUSE_LOAD = 26'(PAUSE_CYCLES - 1);
  logic [25:0] pcnt_q, pcnt_d;
`endif

  rise_det u_flag_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (score_flag),
    .rise_o (flag_rise)
  );

  rise_det u_ng_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (new_game),
    .rise_o (ng_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PLAY;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      evt_q    <= 1'b0;
      winner_q <= PLAYER_FIRST;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      evt_q    <= evt_d;
      winner_q <= winner_d;
    end
  end

`ifdef SCORE_PAUSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= 26'd0;
    else     pcnt_q <= pcnt_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    evt_d    = 1'b0;
    winner_d = winner_q;
`ifdef SCORE_PAUSE_EN
    pcnt_d   = pcnt_q;
`endif
    // A new match request wins over any point scored in the same cycle.
    if (ng_rise) begin
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      winner_d = PLAYER_FIRST;
`ifdef SCORE_PAUSE_EN
      state_d  = PAUSE;
      pcnt_d   = PAUSE_LOAD;
`else
      state_d  = PLAY;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (flag_rise) begin
            evt_d   = 1'b1;
            state_d = SCORED;
            if (xpos >= X_SPL) begin
              if (p1_q < WIN) p1_d = p1_q + 4'd1;
            end else begin
              if (p2_q < WIN) p2_d = p2_q + 4'd1;
            end
          end
        end
        SCORED: begin
          if (!score_flag) begin
            if (p1_q == WIN || p2_q == WIN) begin
              state_d  = GAME_OVER;
              winner_d = (p2_q == WIN) ? PLAYER_SECOND : PLAYER_FIRST;
            end else begin
`ifdef SCORE_PAUSE_EN
              state_d = PAUSE;
              pcnt_d  = PAUSE_LOAD;
`else
              state_d = PLAY;
`endif
            end
          end
        end
`ifdef SCORE_PAUSE_EN
        PAUSE: begin
          if (pcnt_q == 26'd0) state_d = PLAY;
          else                 pcnt_d  = pcnt_q - 26'd1;
        end
`endif
        GAME_OVER: state_d = GAME_OVER;
        default:   state_d = PLAY;
      endcase
    end
  end

  always_comb begin
    points_first_player  = p1_q;
    points_second_player = p2_q;
    score_evt            = evt_q;
    serve_hold           = (state_q != PLAY);
    game_over            = (state_q == GAME_OVER);
    winner               = winner_q;
  end

endmodule

// File: tb/tb_score_ctl.sv
// Self-checking bench for score_ctl: vector table plus a scoreboard of awarded points.
module tb_score_ctl;

`ifdef SCORE_PAUSE_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int PAUSE_N = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        score_flag;
  logic [10:0] xpos;
  logic        new_game;
  logic [3:0]  points_first_player;
  logic [3:0]  points_second_player;
  logic        score_evt;
  logic        serve_hold;
  logic        game_over;
  logic        winner;

  score_ctl #(
    .WIN_POINTS   (9),
    .X_MID        (512),
    .PAUSE_CYCLES (PAUSE_N)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .score_flag           (score_flag),
    .xpos                 (xpos),
    .new_game             (new_game),
    .points_first_player  (points_first_player),
    .points_second_player (points_second_player),
    .score_evt            (score_evt),
    .serve_hold           (serve_hold),
    .game_over            (game_over),
    .winner               (winner)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int evt_seen = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [10:0] xpos;
    int          hold;
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic        go;
    int          evts;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each awarded point must match the next expected score pair.
  always @(negedge clk) begin
    if (score_evt) begin
      evt_seen++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_evt: got p1=%0d p2=%0d, expected no score_evt",
                 points_first_player, points_second_player);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("sb_p1", int'(points_first_player), int'(e[7:4]));
        chk("sb_p2", int'(points_second_player), int'(e[3:0]));
      end
    end
  end

  task automatic count_hold(input string name, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!serve_hold) break;
      n++;
      tick();
    end
    chk(name, n, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    rst = 1'b1; score_flag = 1'b0; xpos = 11'd0; new_game = 1'b0;

    vecs.push_back('{11'd1024, 1,   4'd1, 4'd0, 1'b0, 1});
    vecs.push_back('{11'd0,    100, 4'd1, 4'd1, 1'b0, 1});
    vecs.push_back('{11'd512,  2,   4'd2, 4'd1, 1'b0, 1});
    vecs.push_back('{11'd511,  3,   4'd2, 4'd2, 1'b0, 1});
    for (int k = 3; k <= 9; k++)
      vecs.push_back('{11'(700 + k), 1, 4'(k), 4'd2, (k == 9), 1});
    vecs.push_back('{11'd900,  1,   4'd9, 4'd2, 1'b1, 0});
    vecs.push_back('{11'd5,    4,   4'd9, 4'd2, 1'b1, 0});

    repeat (3) tick();
    chk("rst_p1", int'(points_first_player), 0);
    chk("rst_p2", int'(points_second_player), 0);
    chk("rst_evt", int'(score_evt), 0);
    chk("rst_hold", int'(serve_hold), 0);
    chk("rst_go", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    rst = 1'b0;
    repeat (2) tick();

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (v.evts != 0) sb.push_back({v.p1, v.p2});
      e0 = evt_seen;
      xpos = v.xpos;
      score_flag = 1'b1;
      repeat (v.hold) tick();
      chk($sformatf("v%0d_hold_flag", i), int'(serve_hold), 1);
      score_flag = 1'b0;
      repeat (20) tick();
      chk($sformatf("v%0d_evts", i), evt_seen - e0, v.evts);
      chk($sformatf("v%0d_p1", i), int'(points_first_player), int'(v.p1));
      chk($sformatf("v%0d_p2", i), int'(points_second_player), int'(v.p2));
      chk($sformatf("v%0d_go", i), int'(game_over), int'(v.go));
      chk($sformatf("v%0d_hold", i), int'(serve_hold), int'(v.go));
      if (v.go) chk($sformatf("v%0d_winner", i), int'(winner), 0);
    end

    // New match from GAME_OVER.
    new_game = 1'b1;
    tick();
    chk("ng_p1", int'(points_first_player), 0);
    chk("ng_p2", int'(points_second_player), 0);
    chk("ng_go", int'(game_over), 0);
    chk("ng_hold", int'(serve_hold), PEN);
    new_game = 1'b0;
    repeat (20) tick();
    chk("ng_settle_hold", int'(serve_hold), 0);

    // Serve hold length after a single point.
    sb.push_back({4'd0, 4'd1});
    e0 = evt_seen;
    xpos = 11'd0;
    score_flag = 1'b1;
    tick();
    score_flag = 1'b0;
    count_hold("hold_len", PEN ? 1 + PAUSE_N : 1);
    chk("hold_len_evts", evt_seen - e0, 1);

    // new_game and score edge together; then reset mid-pause.
    repeat (3) tick();
    xpos = 11'd0;
    new_game = 1'b1;
    score_flag = 1'b1;
    tick();
    chk("sim_p1", int'(points_first_player), 0);
    chk("sim_p2", int'(points_second_player), 0);
    repeat (3) tick();
    chk("sim_hold", int'(serve_hold), PEN);
    chk("sim_p2_late", int'(points_second_player), 0);
    new_game = 1'b0;
    score_flag = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_hold", int'(serve_hold), 0);
    chk("arst_p1", int'(points_first_player), 0);
    chk("arst_p2", int'(points_second_player), 0);
    chk("arst_go", int'(game_over), 0);
    chk("arst_evt", int'(score_evt), 0);
    chk("arst_winner", int'(winner), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_hold", int'(serve_hold), 0);

    // Point after reset: pause length must start fresh.
    sb.push_back({4'd1, 4'd0});
    xpos = 11'd1024;
    score_flag = 1'b1;
    tick();
    score_flag = 1'b0;
    count_hold("post_rst_hold_len", PEN ? 1 + PAUSE_N : 1);
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/score_ctl.md
# score_ctl

Match scorekeeper sitting directly downstream of `ball_ctl`. It consumes `score_flag` and the ball `xpos`, decides which player scored, and maintains the two 4-bit point counters that feed back into `ball_ctl` and the score display. It detects the end of the match, freezes play until a new game is requested, and optionally holds the serve for a fixed pause after every point.

## Interface
Parameters:
- `WIN_POINTS`, 9: points needed to win; legal range 1..15.
- `X_MID`, 512: horizontal split of the 1024-pixel field; `xpos >= X_MID` means the ball left on the right.
- `PAUSE_CYCLES`, 32_500_000: serve pause length in clock cycles, about 0.5 s at 65 MHz; ≥ 2. Used only with `SCORE_PAUSE_EN`.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `score_flag` in 1: level from `ball_ctl`, high while the ball is out of field.
- `xpos` in 11: ball x position from `ball_ctl`.
- `new_game` in 1: synchronised button level; its rising edge starts a new match.
- `points_first_player` out 4: left player score.
- `points_second_player` out 4: right player score.
- `score_evt` out 1: one-cycle pulse when a point is awarded.
- `serve_hold` out 1: while high, `ball_ctl` parks the ball at centre.
- `game_over` out 1: match finished.
- `winner` out 1: 0 means the first player won, 1 means the second; valid only while `game_over` is high.

## Operation
- Score detection uses the rising edge of `score_flag` (the flag registered against its previous value). A point scores once, no matter how long the flag stays high.
- Scorer on a `score_flag` rising edge:
  - `xpos >= X_MID`: first player scores.
  - `xpos < X_MID`: second player scores.
- Both counters saturate at `WIN_POINTS` and never wrap.
- FSM states are PLAY, SCORED, PAUSE, GAME_OVER.
- PLAY:
  - On a `score_flag` rising edge: increment the scorer's counter, pulse `score_evt`, go to SCORED.
- SCORED: wait until `score_flag` is low, then:
  - If either counter equals `WIN_POINTS`: go to GAME_OVER and latch `winner`.
  - Otherwise, with the pause enabled: go to PAUSE.
  - Otherwise, with the pause disabled: go to PLAY.
- PAUSE: count `PAUSE_CYCLES` cycles, then go to PLAY.
- GAME_OVER:
  - Counters and `winner` are frozen.
  - `score_flag` is ignored.
- A `new_game` rising edge in any state:
  - clears both counters and `winner`;
  - goes to PAUSE if the pause is enabled, otherwise to PLAY.
- `new_game` has priority over a simultaneous `score_flag` edge. The point is discarded.
- `serve_hold` is high in SCORED, PAUSE and GAME_OVER, and low in PLAY.
- `game_over` is high only in GAME_OVER.

## Timing
- Reset values: state PLAY; both counters 0; `score_evt`, `serve_hold`, `game_over` and `winner` all 0; edge-detect registers 0.
- Reset asserted mid-match or mid-pause returns immediately to these values. The pause counter is cleared.
- Score latency:
  - `score_flag` goes high on cycle N.
  - On N+1, the counter is updated, `score_evt` is high for that cycle only, `serve_hold` goes high, and the state is SCORED.
- SCORED lasts at least 1 cycle.
  - If `score_flag` is already low at N+1, the exit transition happens at the N+2 edge.
  - `game_over` is asserted at N+2 in that case.
- PAUSE lasts exactly `PAUSE_CYCLES` cycles. `serve_hold` falls on the cycle PLAY is entered.
- A `new_game` rising edge on cycle M takes effect at M+1: counters read 0 and `game_over` is low.
- `xpos` is sampled in the same cycle as the `score_flag` edge is detected.

## Configuration
- Macro: `SCORE_PAUSE_EN`.
- Defined:
  - PAUSE state and a 26-bit down-counter are present.
  - SCORED (non-winning) and `new_game` go to PAUSE.
- Undefined:
  - No PAUSE state and no counter logic.
  - SCORED goes to PLAY as soon as `score_flag` is low.
  - `new_game` goes straight to PLAY.
  - `PAUSE_CYCLES` is unused.

## Structure
- `pong_pkg` holds:
  - `score_state_t` enum (PLAY, SCORED, PAUSE, GAME_OVER);
  - field constants `HOR_PIXELS = 1024` and `VER_PIXELS = 768`;
  - `PLAYER_FIRST = 1'b0` and `PLAYER_SECOND = 1'b1`.
- Sub-module `rise_det` is a one-bit registered rising-edge detector with async reset. It is instantiated twice, once for `score_flag` and once for `new_game`.

## Test plan
1. Reset, then `score_flag` pulse with `xpos = 1024` → `points_first_player = 1`, `score_evt` high for exactly 1 cycle, second counter 0.
2. `score_flag` held high for 100 cycles with `xpos = 0` → `points_second_player` increments by exactly 1; state stays SCORED until the flag drops.
3. Nine right-exit points with `WIN_POINTS = 9` → `game_over = 1` and `winner = 0`; a further `score_flag` pulse leaves `points_first_player = 9`.
4. From GAME_OVER, a `new_game` rising edge → next cycle both counters are 0, `game_over = 0` and `serve_hold` reflects the macro setting.
5. With `SCORE_PAUSE_EN` and `PAUSE_CYCLES = 10`, one point → `serve_hold` stays high for 1 + 10 cycles after `score_evt`, then low.
6. `new_game` and `score_flag` rising in the same cycle, then reset asserted mid-pause → counters stay 0; after reset, all outputs are 0 and the state is PLAY.
